inst_sram_responder: RTL
========================

Name: inst_sram_responder

Overview:
Synthesizable instruction-memory slave that answers the fetch-side SRAM request interface: en/we/addr/wdata in, rdata out one cycle later. It sits between the IF stage and the memory array. It honours the IF stage's implicit contract that rdata stays stable while a stage stall holds en low. It also provides a word-wide preload port, address-range checking and access counters used by the bench and for performance bring-up.

Parameters:
ADDR_WIDTH, 12, word-index bits; the array holds 2^ADDR_WIDTH 32-bit words (16 KB at default).
BASE_ADDR, 32'h1c000000, byte base of the array; must be aligned to 2^(ADDR_WIDTH+2).
OOR_DATA, 32'h03400000, word returned for out-of-range reads (LoongArch nop).

Ports:
clk  in  1  clock
resetn  in  1  synchronous, active-low reset
sram_en  in  1  request valid this cycle
sram_we  in  4  byte write enables; 4'b0 means read
sram_addr  in  32  byte address; bits [1:0] ignored
sram_wdata  in  32  write data
sram_rdata  out  32  read data, valid the cycle after a read request
ld_valid  in  1  preload write request
ld_ready  out  1  preload accepted when ld_valid&&ld_ready
ld_addr  in  32  preload byte address; bits [1:0] ignored
ld_data  in  32  preload word
rd_cnt  out  32  accepted in-range core reads, saturating
wr_cnt  out  32  accepted in-range core writes, saturating
oor_err  out  1  sticky: an out-of-range core access or preload occurred

Behaviour:
- Reset (resetn=0 at a clk edge): sram_rdata<=0, rd_cnt<=0, wr_cnt<=0, oor_err<=0. Array contents are NOT reset and persist across reset. Any request or preload during a reset cycle is ignored: no write occurs and no counter changes.
- In range: addr[31:ADDR_WIDTH+2]==BASE_ADDR[31:ADDR_WIDTH+2]. Word index = addr[ADDR_WIDTH+1:2].
- Core read (en=1, we=0):
  - In range: sram_rdata <= mem[idx] at the next edge (1-cycle latency); rd_cnt++.
  - Out of range: sram_rdata <= OOR_DATA; oor_err<=1; no count.
- Core write (en=1, we!=0):
  - In range: byte lane i of mem[idx] is replaced by wdata[8i+7:8i] where we[i]=1; wr_cnt++.
  - sram_rdata <= pre-write contents of mem[idx] (read-first).
  - Out of range: write dropped; sram_rdata<=OOR_DATA; oor_err<=1.
- en=0: sram_rdata holds its value indefinitely. This is mandatory: a stalled IF stage re-samples the same instruction every cycle.
- Read-after-write: a read the cycle after a write to the same word returns the merged data.
- Preload port:
  - ld_ready = resetn && !sram_en (combinational). The core port has strict priority, so a preload is never accepted in a cycle with a core request.
  - On handshake, full-word write of ld_data to mem[idx]. sram_rdata is unaffected; counters unaffected.
  - Out-of-range preload is dropped and sets oor_err.
- Counters saturate at 32'hffffffff and do not wrap.
- oor_err clears only on reset.

Decomposition:
- Shared package/header (alongside BUS_LEN.vh): RESET_PC_BASE 32'h1c000000, NOP_INST 32'h03400000, SRAM interface widths (addr 32, data 32, we 4).
- One sub-module, inst_sram_array: 2^ADDR_WIDTH x 32 storage with a single write port (32-bit byte-enable mask) and a registered read port with hold-enable.
- The top level holds range decode, port arbitration, counters and oor_err.

Test Plan:
1. Preload 0x1c000000<=0x11111111 and 0x1c000004<=0x22222222 with sram_en=0 (ld_ready=1). Then read 0x1c000000 and 0x1c000004 back-to-back -> rdata 0x11111111 then 0x22222222, each one cycle after its request; rd_cnt=2.
2. Read 0x1c000004, then hold en=0 for 5 cycles -> rdata stays 0x22222222 throughout; rd_cnt unchanged.
3. Write we=4'b0101, wdata=0xAABBCCDD to 0x1c000000 -> rdata next cycle=0x11111111 (read-first). A following read returns 0x11BB11DD; wr_cnt=1.
4. Read 0x00000000 -> rdata=0x03400000, oor_err=1, rd_cnt unchanged. Write to 0x20000000 -> array unchanged, wr_cnt unchanged.
5. ld_valid=1 with sram_en=1 in the same cycle -> ld_ready=0 and no preload. Next cycle with en=0 -> ld_ready=1 and the preload lands.
6. Pulse resetn=0 for one cycle during a read of 0x1c000004 -> rdata=0, counters=0, oor_err=0. A subsequent read of 0x1c000004 still returns the preloaded data, confirming the array survives reset.

Source files
------------

// File: rtl/inst_sram_responder_pkg.sv
// Shared constants and helpers for the fetch-side instruction SRAM responder.
// Widths match the core's SRAM request interface.
package inst_sram_responder_pkg;

  localparam int SRAM_ADDR_W = 32;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_WE_W   = 4;

  localparam logic [31:0] RESET_PC_BASE = 32'h1c00_0000;
  localparam logic [31:0] NOP_INST      = 32'h0340_0000;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_CORE_RD,
    ACC_CORE_WR,
    ACC_PRELOAD
  } acc_kind_e;

  function automatic logic [SRAM_DATA_W-1:0] we_to_mask(input logic [SRAM_WE_W-1:0] we);
    logic [SRAM_DATA_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < SRAM_WE_W; i++) begin
      mask[8*i +: 8] = {8{we[i]}};
    end
    return mask;
  endfunction

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hffff_ffff) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/inst_sram_array.sv
// Word-organised instruction storage: one masked write port and a registered
// read port whose output register holds whenever no read is issued.
module inst_sram_array
  import inst_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [31:0]           wr_mask,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  input  logic                  rd_force,
  input  logic [31:0]           rd_force_data,
  output logic [31:0]           rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (!resetn) begin
      rdata_d = '0;
    end else if (rd_en) begin
      rdata_d = rd_force ? rd_force_data : mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  // Storage is never reset; the read above samples the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  assign rd_data = rdata_q;

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction SRAM slave for the IF stage: range decode, core/preload port
// arbitration, access counters and a sticky out-of-range flag around the array.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = RESET_PC_BASE,
  parameter logic [31:0] OOR_DATA   = NOP_INST
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sram_en,
  input  logic [3:0]  sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        oor_err
);

  localparam int TAG_LSB = ADDR_WIDTH + 2;

  logic                  core_hit;
  logic                  ld_hit;
  logic [ADDR_WIDTH-1:0] core_idx;
  logic [ADDR_WIDTH-1:0] ld_idx;
  acc_kind_e             acc_kind;

  logic                  arr_wr_en;
  logic [ADDR_WIDTH-1:0] arr_wr_idx;
  logic [31:0]           arr_wr_mask;
  logic [31:0]           arr_wr_data;
  logic                  arr_rd_en;

  logic [31:0] rd_cnt_d,  rd_cnt_q;
  logic [31:0] wr_cnt_d,  wr_cnt_q;
  logic        oor_err_d, oor_err_q;

  logic unused_addr_lsbs;

  assign core_hit = (sram_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign ld_hit   = (ld_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign core_idx = sram_addr[TAG_LSB-1:2];
  assign ld_idx   = ld_addr[TAG_LSB-1:2];

  assign unused_addr_lsbs = ^{sram_addr[1:0], ld_addr[1:0]};

  // The core port always wins; preload only slips into idle core cycles.
  assign ld_ready = resetn && !sram_en;

  always_comb begin
    acc_kind = ACC_NONE;
    if (resetn) begin
      if (sram_en) begin
        acc_kind = (sram_we == 4'b0000) ? ACC_CORE_RD : ACC_CORE_WR;
      end else if (ld_valid) begin
        acc_kind = ACC_PRELOAD;
      end
    end
  end

  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_idx  = core_idx;
    arr_wr_mask = '0;
    arr_wr_data = sram_wdata;
    arr_rd_en   = 1'b0;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    oor_err_d   = oor_err_q;
    case (acc_kind)
      ACC_CORE_RD: begin
        arr_rd_en = 1'b1;
        if (core_hit) begin
          rd_cnt_d = sat_inc(rd_cnt_q);
        end else begin
          oor_err_d = 1'b1;
        end
      end
      ACC_CORE_WR: begin
        arr_rd_en = 1'b1;
        if (core_hit) begin
          arr_wr_en   = 1'b1;
          arr_wr_mask = we_to_mask(sram_we);
          wr_cnt_d    = sat_inc(wr_cnt_q);
        end else begin
          oor_err_d = 1'b1;
        end
      end
      ACC_PRELOAD: begin
        if (ld_hit) begin
          arr_wr_en   = 1'b1;
          arr_wr_idx  = ld_idx;
          arr_wr_mask = 32'hffff_ffff;
          arr_wr_data = ld_data;
        end else begin
          oor_err_d = 1'b1;
        end
      end
      default: begin
        arr_wr_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      oor_err_q <= 1'b0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      oor_err_q <= oor_err_d;
    end
  end

  inst_sram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (arr_wr_en),
    .wr_idx       (arr_wr_idx),
    .wr_mask      (arr_wr_mask),
    .wr_data      (arr_wr_data),
    .rd_en        (arr_rd_en),
    .rd_idx       (core_idx),
    .rd_force     (!core_hit),
    .rd_force_data(OOR_DATA),
    .rd_data      (sram_rdata)
  );

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign oor_err = oor_err_q;

endmodule
